// File: rtl/ats_pkg.sv
// ats_pkg: shared types for the ATS alarm/timer bank.
// Opcodes, response codes, field positions, response word.
package ats_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'b000,
    SETCLK = 3'b001,
    ENCLK  = 3'b010,
    MODE   = 3'b011,
    READ   = 3'b100,
    SETALM = 3'b101,
    SETTMR = 3'b110,
    ENALM  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_RB  = 2'b01,
    ST_ERR = 2'b10,
    ST_EVT = 2'b11
  } stat_e;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_HI   = 1'b1
  } beat_e;

  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 13;
  localparam int F_CH_HI  = 12;
  localparam int F_CH_LO  = 8;
  localparam int F_ACT    = 12;
  localparam int F_LOCK   = 11;
  localparam int F_RPT    = 7;
  localparam int F_SRC_HI = 3;
  localparam int F_SRC_LO = 0;

  typedef struct packed {
    op_e        op;
    logic [4:0] ch;
    logic       rpt;
    logic [3:0] src;
    logic       act;
    logic       lock;
  } cmd_hi_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] val;
  } rsp_t;

  function automatic cmd_hi_t hi_fields(logic [15:0] w);
    cmd_hi_t f;
    f.op   = op_e'(w[F_OP_HI:F_OP_LO]);
    f.ch   = w[F_CH_HI:F_CH_LO];
    f.rpt  = w[F_RPT];
    f.src  = w[F_SRC_HI:F_SRC_LO];
    f.act  = w[F_ACT];
    f.lock = w[F_LOCK];
    return f;
  endfunction

endpackage

// File: rtl/ats_channel.sv
// ats_channel: one alarm/countdown channel.
// Holds config, count, pending flag and captured expiry time.
module ats_channel
  import ats_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_cfg,
  input  logic        cfg_mode,
  input  logic        cfg_rpt,
  input  logic [3:0]  cfg_src,
  input  logic [15:0] cfg_val,
  input  logic        wr_en,
  input  logic        en_val,
  input  logic        tk,
  input  logic [15:0] tnext,
  input  logic        clr_pend,
  output logic        fire,
  output logic        pend,
  output logic        en,
  output logic        mode,
  output logic        rpt,
  output logic [3:0]  src,
  output logic [15:0] rb_val,
  output logic [15:0] cap
);

  logic [15:0] val_q;
  logic [15:0] cnt_q;
  logic        go;
  logic        hit;

  // A tick counts only when enabled and no command touches us
  always_comb begin
    go  = en && tk && !wr_cfg && !wr_en;
    hit = 1'b0;
    if (go) begin
      if (mode) hit = (cnt_q <= 16'd1);
      else      hit = (tnext == val_q);
    end
  end

  assign rb_val = mode ? cnt_q : val_q;

  // Channel configuration and countdown state
  always_ff @(posedge clk) begin
    if (reset) begin
      en    <= 1'b0;
      mode  <= 1'b0;
      rpt   <= 1'b0;
      src   <= '0;
      val_q <= '0;
      cnt_q <= '0;
    end else if (wr_cfg) begin
      en    <= 1'b0;
      mode  <= cfg_mode;
      rpt   <= cfg_rpt;
      src   <= cfg_src;
      val_q <= cfg_val;
      cnt_q <= cfg_val;
    end else if (wr_en) begin
      en <= en_val;
    end else if (go) begin
      if (mode) begin
        if (hit) begin
          cnt_q <= rpt ? val_q : 16'd0;
          if (!rpt) en <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 16'd1;
        end
      end else if (hit && !rpt) begin
        en <= 1'b0;
      end
    end
  end

  // Expiry pulse, pending flag and captured source time
  always_ff @(posedge clk) begin
    if (reset) begin
      fire <= 1'b0;
      pend <= 1'b0;
      cap  <= '0;
    end else begin
      fire <= hit;
      pend <= (pend && !clr_pend) || hit;
      if (hit) cap <= tnext;
    end
  end

endmodule

// File: rtl/ats_alarm_bank.sv
// ats_alarm_bank: two-beat command decoder, time bases,
// N_CH alarm/timer channels and the response arbiter.
module ats_alarm_bank
  import ats_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int N_CLK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [15:0]      ctrlA,
  input  logic [N_CLK-1:0] tick,
  output logic             ready,
  output logic [1:0]       stat,
  output logic [23:0]      data,
  output logic [N_CH-1:0]  fire
);

  beat_e   st_q;
  beat_e   st_d;
  cmd_hi_t hi_q;
  logic    active_q;
  logic    lock_q;

  logic [15:0]      time_q [N_CLK];
  logic [N_CLK-1:0] tk_act;
  logic [15:0]      tk16;
  logic [15:0]      tnx [16];

  logic            exec;
  logic            abort;
  logic            ch_ok;
  logic            src_ok;
  logic            cmd_v;
  stat_e           cmd_st;
  rsp_t            cmd_rsp;
  logic            wr_mode;
  logic            cfg_mode;
  logic [N_CH-1:0] wr_cfg;
  logic [N_CH-1:0] wr_en;
  logic [N_CH-1:0] chsel;
  rsp_t            rb;

  logic [N_CH-1:0] ch_pend;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] ch_mode;
  logic [N_CH-1:0] ch_rpt;
  logic [3:0]      ch_src [N_CH];
  logic [15:0]     ch_val [N_CH];
  logic [15:0]     ch_cap [N_CH];

  logic            rv_q;
  stat_e           rs_q;
  rsp_t            rd_q;
  logic [4:0]      gidx;
  logic [N_CH-1:0] gsel;
  logic [N_CH-1:0] clr;
  rsp_t            ev;

  // Beat state register
  always_ff @(posedge clk) begin
    if (reset) st_q <= B_IDLE;
    else       st_q <= st_d;
  end

  // Beat next state: beat 2 or a dropped req both end the command
  always_comb begin
    st_d = B_IDLE;
    if (st_q == B_IDLE && req) st_d = B_HI;
  end

  // Latch the fields of beat 1
  always_ff @(posedge clk) begin
    if (reset)                     hi_q <= '0;
    else if (st_q == B_IDLE && req) hi_q <= hi_fields(ctrlA);
  end

  // Channel select and read-back mux
  always_comb begin
    chsel = '0;
    rb    = '0;
    for (int i = 0; i < N_CH; i++) begin
      chsel[i] = (hi_q.ch == 5'(i));
      if (chsel[i]) begin
        rb.tag = {ch_en[i], ch_mode[i], ch_rpt[i], 5'b0};
        rb.val = ch_val[i];
      end
    end
  end

  // Command decode: response and write strobes
  always_comb begin
    exec     = (st_q == B_HI) && req;
    abort    = (st_q == B_HI) && !req;
    ch_ok    = int'(hi_q.ch) < N_CH;
    src_ok   = int'(hi_q.src) < N_CLK;
    cmd_v    = exec || abort;
    cmd_st   = ST_OK;
    cmd_rsp  = '0;
    wr_mode  = 1'b0;
    cfg_mode = 1'b0;
    wr_cfg   = '0;
    wr_en    = '0;
    if (abort) begin
      cmd_st = ST_ERR;
    end else if (exec) begin
      unique case (1'b1)
        (hi_q.op == NOP): ;
        (hi_q.op == MODE): wr_mode = 1'b1;
        (hi_q.op == READ): begin
          if (ch_ok) begin
            cmd_st  = ST_RB;
            cmd_rsp = rb;
          end else begin
            cmd_st = ST_ERR;
          end
        end
        (hi_q.op == SETALM),
        (hi_q.op == SETTMR): begin
          if (ch_ok && src_ok && !lock_q) begin
            wr_cfg   = chsel;
            cfg_mode = (hi_q.op == SETTMR);
          end else begin
            cmd_st = ST_ERR;
          end
        end
        (hi_q.op == ENALM): begin
          if (ch_ok && !lock_q) wr_en = chsel;
          else                  cmd_st = ST_ERR;
        end
        default: cmd_st = ST_ERR;
      endcase
    end
  end

  // Global active/lock mode bits
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b1;
      lock_q   <= 1'b0;
    end else if (wr_mode) begin
      active_q <= hi_q.act;
      lock_q   <= hi_q.lock;
    end
  end

  assign tk_act = tick & {N_CLK{active_q}};

  // Per-source time counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CLK; k++) time_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CLK; k++)
        if (tk_act[k]) time_q[k] <= time_q[k] + 16'd1;
    end
  end

  // Pad ticks and next-times to the full 4-bit source space
  always_comb begin
    tk16 = '0;
    for (int k = 0; k < 16; k++) tnx[k] = '0;
    for (int k = 0; k < N_CLK; k++) begin
      tk16[k] = tk_act[k];
      tnx[k]  = time_q[k] + 16'd1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ats_channel u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_cfg   (wr_cfg[i]),
      .cfg_mode (cfg_mode),
      .cfg_rpt  (hi_q.rpt),
      .cfg_src  (hi_q.src),
      .cfg_val  (ctrlA),
      .wr_en    (wr_en[i]),
      .en_val   (hi_q.rpt),
      .tk       (tk16[ch_src[i]]),
      .tnext    (tnx[ch_src[i]]),
      .clr_pend (clr[i]),
      .fire     (fire[i]),
      .pend     (ch_pend[i]),
      .en       (ch_en[i]),
      .mode     (ch_mode[i]),
      .rpt      (ch_rpt[i]),
      .src      (ch_src[i]),
      .rb_val   (ch_val[i]),
      .cap      (ch_cap[i])
    );
  end

  // Registered command response
  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q <= 1'b0;
      rs_q <= ST_OK;
      rd_q <= '0;
    end else begin
      rv_q <= cmd_v;
      rs_q <= cmd_st;
      rd_q <= cmd_rsp;
    end
  end

  // Lowest pending channel wins a free slot
  always_comb begin
    gidx = '0;
    gsel = '0;
    ev   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_pend[i]) begin
        gidx    = 5'(i);
        gsel    = '0;
        gsel[i] = 1'b1;
        ev.val  = ch_cap[i];
      end
    end
    ev.tag = {3'b0, gidx};
    clr    = rv_q ? '0 : gsel;
  end

  // Response port: command first, else an event
  always_comb begin
    ready = 1'b0;
    stat  = ST_OK;
    data  = '0;
    if (rv_q) begin
      ready = 1'b1;
      stat  = rs_q;
      data  = rd_q;
    end else if (|ch_pend) begin
      ready = 1'b1;
      stat  = ST_EVT;
      data  = ev;
    end
  end

endmodule

// File: tb/tb_ats_alarm_bank.sv
// tb_ats_alarm_bank: directed vectors and corner sequences
// for the ATS alarm/timer bank.
module tb_ats_alarm_bank;

  localparam int N_CH  = 8;
  localparam int N_CLK = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic [15:0]      ctrlA;
  logic [N_CLK-1:0] tick;
  logic             ready;
  logic [1:0]       stat;
  logic [23:0]      data;
  logic [N_CH-1:0]  fire;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ats_alarm_bank #(.N_CH(N_CH), .N_CLK(N_CLK)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ctrlA (ctrlA),
    .tick  (tick),
    .ready (ready),
    .stat  (stat),
    .data  (data),
    .fire  (fire)
  );

  typedef struct {
    string       nm;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [1:0]  st;
    logic [23:0] dat;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] mk(int op, int ch, int r, int s);
    return 16'((op << 13) | (ch << 8) | (r << 7) | s);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(string nm, logic [15:0] hi, logic [15:0] lo,
                     logic [1:0] st, logic [23:0] dat);
    vec_t v;
    v.nm = nm; v.hi = hi; v.lo = lo; v.st = st; v.dat = dat;
    tbl.push_back(v);
  endtask

  task automatic cmd(string nm, logic [15:0] hi, logic [15:0] lo,
                     logic [1:0] es, logic [23:0] ed);
    @(negedge clk); req = 1'b1; ctrlA = hi;
    @(negedge clk); ctrlA = lo;
    @(negedge clk); req = 1'b0; ctrlA = '0;
    chk({nm, ".rdy"}, 32'(ready), 32'd1);
    chk({nm, ".stat"}, 32'(stat), 32'(es));
    chk({nm, ".data"}, 32'(data), 32'(ed));
  endtask

  task automatic pulse(string nm, logic [N_CLK-1:0] m,
                       logic [N_CH-1:0] ef);
    @(negedge clk); tick = m;
    @(negedge clk); tick = '0;
    chk({nm, ".fire"}, 32'(fire), 32'(ef));
  endtask

  task automatic evt(string nm, logic [23:0] ed);
    chk({nm, ".rdy"}, 32'(ready), 32'd1);
    chk({nm, ".stat"}, 32'(stat), 32'd3);
    chk({nm, ".data"}, 32'(data), 32'(ed));
  endtask

  int          nf;
  int          last;
  logic [23:0] seen;

  initial begin
    reset = 1'b1; req = 1'b0; ctrlA = '0; tick = '0;
    repeat (3) @(negedge clk);
    chk("rst.rdy", 32'(ready), 32'd0);
    chk("rst.stat", 32'(stat), 32'd0);
    chk("rst.data", 32'(data), 32'd0);
    chk("rst.fire", 32'(fire), 32'd0);
    reset = 1'b0;

    add("nop",     mk(0, 0, 0, 0), 16'h0,    2'd0, 24'h0);
    add("rd0",     mk(4, 0, 0, 0), 16'h0,    2'd1, 24'h0);
    add("alm_ch8", mk(5, 8, 0, 0), 16'h7,    2'd2, 24'h0);
    add("op001",   mk(1, 0, 0, 0), 16'h0,    2'd2, 24'h0);
    add("op010",   mk(2, 0, 0, 0), 16'h0,    2'd2, 24'h0);
    add("tmr_src", mk(6, 3, 0, 4), 16'h3,    2'd2, 24'h0);
    add("en_ch31", mk(7, 31, 1, 0), 16'h0,   2'd2, 24'h0);
    add("rd_ch8",  mk(4, 8, 0, 0), 16'h0,    2'd2, 24'h0);
    add("alm5",    mk(5, 5, 1, 3), 16'h1234, 2'd0, 24'h0);
    add("rd5a",    mk(4, 5, 0, 0), 16'h0,    2'd1, 24'h201234);
    add("tmr5",    mk(6, 5, 0, 3), 16'hBEEF, 2'd0, 24'h0);
    add("rd5t",    mk(4, 5, 0, 0), 16'h0,    2'd1, 24'h40BEEF);
    add("en5",     mk(7, 5, 1, 0), 16'h0,    2'd0, 24'h0);
    add("rd5e",    mk(4, 5, 0, 0), 16'h0,    2'd1, 24'hC0BEEF);
    add("dis5",    mk(7, 5, 0, 0), 16'h0,    2'd0, 24'h0);
    foreach (tbl[i]) cmd(tbl[i].nm, tbl[i].hi, tbl[i].lo,
                         tbl[i].st, tbl[i].dat);

    // one-shot timer ch3 on src1, interval 3
    cmd("t3.set", mk(6, 3, 0, 1), 16'd3, 2'd0, 24'h0);
    cmd("t3.en", mk(7, 3, 1, 0), 16'd0, 2'd0, 24'h0);
    pulse("t3.k1", 4'b0010, 8'h00);
    pulse("t3.k2", 4'b0010, 8'h00);
    pulse("t3.k3", 4'b0010, 8'h08);
    evt("t3.ev", 24'h030003);
    @(negedge clk);
    chk("t3.idle", 32'(ready), 32'd0);
    cmd("t3.rd", mk(4, 3, 0, 0), 16'd0, 2'd1, 24'h400000);

    // repeating alarm ch0 on src0, target 5
    cmd("a0.set", mk(5, 0, 1, 0), 16'd5, 2'd0, 24'h0);
    cmd("a0.en", mk(7, 0, 1, 0), 16'd0, 2'd0, 24'h0);
    for (int p = 1; p <= 4; p++) pulse("a0.pre", 4'b0001, 8'h00);
    pulse("a0.k5", 4'b0001, 8'h01);
    evt("a0.ev", 24'h000005);
    nf = 0; last = -1; seen = '0;
    @(negedge clk); tick = 4'b0001;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (fire[0]) begin
        nf++;
        last = i;
        seen = data;
      end
    end
    tick = '0;
    chk("a0.wrap_n", 32'(nf), 32'd1);
    chk("a0.wrap_at", 32'(last), 32'd65535);
    chk("a0.wrap_ev", 32'(seen), 32'h000005);
    @(negedge clk);
    cmd("a0.rd", mk(4, 0, 0, 0), 16'd0, 2'd1, 24'hA00005);

    // two repeating timers, same tick, command takes first slot
    cmd("t1.set", mk(6, 1, 1, 2), 16'd1, 2'd0, 24'h0);
    cmd("t2.set", mk(6, 2, 1, 2), 16'd1, 2'd0, 24'h0);
    cmd("t1.en", mk(7, 1, 1, 0), 16'd0, 2'd0, 24'h0);
    cmd("t2.en", mk(7, 2, 1, 0), 16'd0, 2'd0, 24'h0);
    @(negedge clk); req = 1'b1; ctrlA = mk(0, 0, 0, 0);
    @(negedge clk); ctrlA = '0; tick = 4'b0100;
    @(negedge clk); req = 1'b0; tick = '0;
    chk("pr.cmd_rdy", 32'(ready), 32'd1);
    chk("pr.cmd_st", 32'(stat), 32'd0);
    chk("pr.fire", 32'(fire), 32'h06);
    @(negedge clk);
    evt("pr.ev1", 24'h010001);
    chk("pr.fire0", 32'(fire), 32'h00);
    @(negedge clk);
    evt("pr.ev2", 24'h020001);
    @(negedge clk);
    chk("pr.idle", 32'(ready), 32'd0);

    // command on ch1 in tick cycle: ch1 loses the tick
    @(negedge clk); req = 1'b1; ctrlA = mk(7, 1, 1, 0);
    @(negedge clk); ctrlA = '0; tick = 4'b0100;
    @(negedge clk); req = 1'b0; tick = '0;
    chk("cw.st", 32'(stat), 32'd0);
    chk("cw.fire", 32'(fire), 32'h04);
    @(negedge clk);
    evt("cw.ev", 24'h020002);
    @(negedge clk);
    chk("cw.idle", 32'(ready), 32'd0);

    // lock and inactive mode
    cmd("lk.on", mk(3, 24, 0, 0), 16'd0, 2'd0, 24'h0);
    cmd("lk.set", mk(5, 0, 0, 0), 16'd9, 2'd2, 24'h0);
    cmd("lk.en", mk(7, 0, 0, 0), 16'd0, 2'd2, 24'h0);
    cmd("lk.rd", mk(4, 0, 0, 0), 16'd0, 2'd1, 24'hA00005);
    cmd("lk.off", mk(3, 16, 0, 0), 16'd0, 2'd0, 24'h0);
    cmd("ia.off", mk(3, 0, 0, 0), 16'd0, 2'd0, 24'h0);
    pulse("ia.tick", 4'b0100, 8'h00);
    chk("ia.rdy", 32'(ready), 32'd0);
    cmd("ia.on", mk(3, 16, 0, 0), 16'd0, 2'd0, 24'h0);
    pulse("ia.tick2", 4'b0100, 8'h06);
    evt("ia.ev1", 24'h010003);
    @(negedge clk);
    evt("ia.ev2", 24'h020003);
    @(negedge clk);
    chk("ia.idle", 32'(ready), 32'd0);

    // req dropped after beat 1
    @(negedge clk); req = 1'b1; ctrlA = mk(0, 0, 0, 0);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("ab.rdy", 32'(ready), 32'd1);
    chk("ab.stat", 32'(stat), 32'd2);
    chk("ab.data", 32'(data), 32'd0);

    // reset between beats
    @(negedge clk); req = 1'b1; ctrlA = mk(0, 0, 0, 0);
    @(negedge clk); req = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rm.rdy0", 32'(ready), 32'd0);
    chk("rm.fire", 32'(fire), 32'd0);
    @(negedge clk);
    chk("rm.rdy1", 32'(ready), 32'd0);
    cmd("rm.nop", mk(0, 0, 0, 0), 16'd0, 2'd0, 24'h0);
    cmd("rm.rd0", mk(4, 0, 0, 0), 16'd0, 2'd1, 24'h0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/ats_alarm_bank.md
# ats_alarm_bank

Parametrised alarm/countdown-timer engine, next generation of the ATS21 alarm/timer datapath. Accepts the two-beat ATS21 command stream (opcodes 000, 011, 101, 110, 111, plus a new read-back opcode 100). Runs N_CH independent channels against N_CLK external tick sources and reports command completions and channel expiries over the ATS21-style ready/stat/data response port. Sits between the command front end and the clock-rate generator, which supplies the tick strobes.

## Interface
- N_CH, 8, number of alarm/timer channels (1..32; index field is 5 bits)
- N_CLK, 4, number of tick sources (1..16; index field is 4 bits)
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  1  command valid; high for both beats of a command
- ctrlA  input  16  command word: beat 1 = high half [1], beat 2 = low half [0]
- tick  input  N_CLK  one-cycle tick strobe per clock source
- ready  output  1  one-cycle response strobe
- stat  output  2  response code: 00 OK, 01 read-back, 10 error, 11 expiry event
- data  output  24  response payload
- fire  output  N_CH  one-cycle pulse per channel on expiry

## Operation
- Beat capture:
  - The first cycle of req=1 latches ctrlA as [1]; the next cycle latches it as [0].
  - req held high continues with the next command's beat 1.
  - req falling after beat 1 discards the command and reports stat=10 with data=0.
- 000 NOP: response stat=00.
- 011 mode:
  - [1][12]=active; when active=0, all ticks are ignored.
  - [1][11]=lock; when lock=1, opcodes 101/110/111 return stat=10 with no state change.
  - Reset: active=1, lock=0.
- 101 set alarm:
  - Fields: ch=[1][12:8], repeat=[1][7], src=[1][3:0], target=[0].
  - Loads the channel in alarm mode and clears its enable.
- 110 set timer:
  - Fields as 101, but [0] is the interval.
  - repeat bit [1][7] is new in this generation.
  - Loads count=interval and clears enable.
- 111 enable: ch=[1][12:8], en=[1][7].
- 100 read-back:
  - ch=[1][12:8]. Responds stat=01.
  - data = {en, mode, repeat, 5'b0, count or target[15:0]}, where mode is 1 for timer.
- Error (stat=10) cases:
  - ch ≥ N_CH, src ≥ N_CLK, or an undefined opcode.
  - No state change in any error case.
- Time base: one 16-bit time counter per source, incremented on tick[k] while active, wrapping 0xFFFF→0.
- Alarm channel:
  - Fires on a tick of src when the incremented time equals target.
  - repeat=0 clears enable on firing; repeat=1 stays enabled and fires again after the 16-bit wrap.
- Timer channel:
  - Decrements count on each tick of src while enabled.
  - Fires on the tick where count goes 1→0, or on the first tick if loaded with 0.
  - On firing: repeat=1 reloads the interval; repeat=0 clears enable and holds 0.
- Event reporting:
  - Expiries set per-channel pending bits.
  - One event is reported per response slot, lowest index first, with stat=11.
  - Event data = {3'b0, ch[4:0], time[15:0] of src at expiry}; the time value is captured in a per-channel register.

## Timing
- Reset values:
  - ready=0, stat=00, data=0, fire=0.
  - All channels disabled, counts/targets 0, pending 0, time counters 0, active=1, lock=0.
  - Beat state returns to idle.
- Reset mid-command discards the command; no response is produced.
- Command latency: the response ready=1 appears in the cycle after beat 2, i.e. t+2 when beat 1 is at t.
- fire[i] asserts in the cycle after the causing tick.
- A command response takes priority over event reporting.
- An event is reported at the earliest cycle with no command response, and no earlier than the cycle fire[i] asserts.
- A deferred event stays pending; a channel firing again while pending sets no extra pending bit and only updates the captured time.
- Command write and tick on the same channel in the same cycle: the command wins and the tick is lost for that channel only. Other channels still see the tick.

## Structure
- Package ats_pkg holds:
  - opcode enum (NOP, SETCLK, ENCLK, MODE, READ, SETALM, SETTMR, ENALM)
  - stat enum
  - field bit-position localparams
  - 24-bit response struct
- Sub-module ats_channel: one channel (mode, repeat, enable, count/target, src, pending), instantiated N_CH times via generate. The bank holds the decoder, time counters and response arbiter.

## Test plan
- Reset, then NOP command → ready=1 at t+2, stat=00, data=0.
- Set timer ch3, src1, interval 3, repeat=0; enable; pulse tick[1] three times → fire[3] once, the cycle after the 3rd tick; event stat=11, data={3'b0,5'd3,time=3}; read-back shows en=0, count=0.
- Set alarm ch0, src0, target 5, repeat=1; enable; 5 ticks on src0 → fires at time 5; after 65536 more ticks, fires again.
- Timers ch1/ch2 repeat=1, interval 1, same tick → two events reported in consecutive free slots, ch1 before ch2; a command issued meanwhile gets its slot first.
- Set ch=N_CH (e.g. 8) → stat=10, no state change; mode lock=1, then set ch0 → stat=10; req dropped after beat 1 → stat=10.
- Reset asserted between beat 1 and beat 2 → no response; a following NOP completes normally.
